// File: rtl/axis_ingress_fifo.sv
// axis_ingress_fifo: buffered AXI-Stream ingress stage in front of the header
// parser. A first-word-fall-through FIFO decouples external backpressure from
// the internal pipeline. Frames longer than MAX_BEATS are truncated: the last
// kept beat gets tlast and tuser[0] forced to 1, and the rest of the frame is
// dropped. Saturating counters track written frames and truncated frames.
//
// Handshake contract (both sides): a beat moves on a rising clk edge where
// valid && ready are both high. A producer holds valid and payload stable
// until the beat moves. s_tready comes from a flop and has no combinational
// path from m_tready. m_* come straight from the FIFO head and hold stable
// while m_tvalid=1 and m_tready=0.
module axis_ingress_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16,
  parameter int MAX_BEATS  = 190,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  input  logic [USER_WIDTH-1:0]     s_tuser,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic [USER_WIDTH-1:0]     m_tuser,
  output logic [CNT_WIDTH-1:0]      frame_cnt,
  output logic [CNT_WIDTH-1:0]      trunc_cnt,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int AW         = $clog2(DEPTH);
  // One FIFO entry: {data, keep, last, user}
  localparam int EW         = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  // bcnt only ever holds 0..MAX_BEATS-1
  localparam int BW         = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic [BW-1:0]        BCNT_LAST = BW'(MAX_BEATS - 1);
  localparam logic [BW-1:0]        BCNT_ONE  = BW'(1);
  localparam logic [AW:0]          LVL_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]          LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
  localparam logic [CNT_WIDTH-1:0] STAT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] STAT_ONE  = CNT_WIDTH'(1);
  localparam logic [USER_WIDTH-1:0] USER_ERR = USER_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_FRAME = 2'd1,
    ST_DISCARD  = 2'd2
  } state_t;

  // Frame-tracking FSM state and the per-frame beat counter
  state_t                 state_q, state_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;

  // FIFO storage, pointers and occupancy
  logic [EW-1:0]          mem_q [DEPTH];
  logic [EW-1:0]          mem_d [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;

  // Registered upstream ready
  logic                   rdy_q, rdy_d;

  // Statistics
  logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]   trunc_cnt_q, trunc_cnt_d;

  // FSM outputs and datapath controls
  logic                   s_acc;
  logic                   wr_en;
  logic [EW-1:0]          wr_entry;
  logic                   frame_inc;
  logic                   trunc_inc;
  logic                   rd_en;
  logic [EW-1:0]          rd_entry;

  assign s_acc    = s_tvalid && rdy_q;
  assign s_tready = rdy_q;

  // FSM state register and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // FSM next state: track frame position, enter DISCARD when the limit is hit
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE, ST_IN_FRAME: begin
        if (s_acc) begin
          if (s_tlast) begin
            // A genuine tlast on the limit beat wins over truncation
            state_d = ST_IDLE;
            bcnt_d  = '0;
          end else if (bcnt_q == BCNT_LAST) begin
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_IN_FRAME;
            bcnt_d  = bcnt_q + BCNT_ONE;
          end
        end
      end
      ST_DISCARD: begin
        if (s_acc && s_tlast) begin
          state_d = ST_IDLE;
          bcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // FSM outputs: FIFO write, truncation rewrite of the limit beat, stat pulses
  always_comb begin
    wr_en     = 1'b0;
    wr_entry  = {s_tdata, s_tkeep, s_tlast, s_tuser};
    frame_inc = 1'b0;
    trunc_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_IN_FRAME: begin
        if (s_acc) begin
          wr_en = 1'b1;
          if (s_tlast) begin
            frame_inc = 1'b1;
          end else if (bcnt_q == BCNT_LAST) begin
            frame_inc = 1'b1;
            trunc_inc = 1'b1;
            wr_entry  = {s_tdata, s_tkeep, 1'b1, s_tuser | USER_ERR};
          end
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // FIFO read side: the head entry is presented whenever occupancy is non-zero
  assign m_tvalid = (count_q != '0);
  assign rd_en    = m_tvalid && m_tready;
  assign rd_entry = mem_q[rd_ptr_q];

  // Outputs read as zero while empty so nothing stale leaks after reset
  assign {m_tdata, m_tkeep, m_tlast, m_tuser} = m_tvalid ? rd_entry : '0;

  // Storage write port
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_entry;
    end
  end

  // Storage array; entries are only read after being written, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointers, occupancy and next upstream ready
  always_comb begin
    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + LVL_ONE;
      2'b01:   count_d = count_q - LVL_ONE;
      default: count_d = count_q;
    endcase
    // DISCARD swallows beats without storing them, so it never backpressures
    rdy_d = (state_d == ST_DISCARD) || (count_d != LVL_FULL);
  end

  // FIFO control registers; ready stays low for the whole reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  // Saturating statistics updates
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    if (frame_inc && (frame_cnt_q != STAT_MAX)) begin
      frame_cnt_d = frame_cnt_q + STAT_ONE;
    end
    if (trunc_inc && (trunc_cnt_q != STAT_MAX)) begin
      trunc_cnt_d = trunc_cnt_q + STAT_ONE;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign trunc_cnt  = trunc_cnt_q;
  assign fill_level = count_q;

endmodule

// File: tb/tb_axis_ingress_fifo.sv
// Bench for axis_ingress_fifo with DEPTH=4, MAX_BEATS=4, USER_WIDTH=2.
// Driver tasks push hand-computed expected beats into exp_q as they are
// accepted; a negedge monitor pops and compares every beat the DUT sends.
module tb_axis_ingress_fifo;

  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int UW    = 2;
  localparam int DEPTH = 4;
  localparam int MAXB  = 4;
  localparam int CW    = 32;
  localparam int EW    = DW + KW + 1 + UW;

  localparam int K_PASS  = 0;
  localparam int K_TRUNC = 1;
  localparam int K_DROP  = 2;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] trunc_cnt;
  logic [$clog2(DEPTH):0] fill_level;

  axis_ingress_fifo #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .DEPTH      (DEPTH),
    .MAX_BEATS  (MAXB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .frame_cnt  (frame_cnt),
    .trunc_cnt  (trunc_cnt),
    .fill_level (fill_level)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  bit            lat_chk  = 1'b0;
  bit            saw_full = 1'b0;
  bit            drv_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_cur;
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] hold_e;
  bit            hold_v = 1'b0;
  int            acc_c;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (hold_v) begin
        check("hold_valid", m_tvalid, 1'b1);
        check("hold_payload", mon_cur, hold_e);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %0h expected no beat", mon_cur);
        end else begin
          mon_exp = exp_q.pop_front();
          acc_c   = lat_q.pop_front();
          check("beat", mon_cur, mon_exp);
          if (lat_chk) check("latency_cycle", cyc, acc_c);
        end
      end
      if (fill_level == DEPTH) saw_full = 1'b1;
      if (fill_level > DEPTH) check("fill_bound", fill_level, DEPTH);
      hold_v = m_tvalid && !m_tready;
      hold_e = mon_cur;
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one beat; kind says what the DUT must emit for it (hand-chosen).
  task automatic send(input logic [DW-1:0] d, input logic last, input logic [UW-1:0] user,
                      input int kind, input bit no_stall);
    int            waits;
    bit            acc;
    logic [KW-1:0] keep;
    logic [UW-1:0] err_user;
    keep     = last ? 8'h0F : 8'hFF;
    err_user = user | 2'b01;
    s_tdata  = d;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tuser  = user;
    s_tvalid = 1'b1;
    waits    = 0;
    acc      = 1'b0;
    while (!acc && waits < 100) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: beat %0h not accepted, expected accept within 100 cycles", d);
    end else begin
      if (kind == K_PASS) begin
        exp_q.push_back({d, keep, last, user});
        lat_q.push_back(cyc);
      end else if (kind == K_TRUNC) begin
        exp_q.push_back({d, keep, 1'b1, err_user});
        lat_q.push_back(cyc);
      end
      if (no_stall) check("no_stall_waits", waits, 0);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fill_level != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
    m_tready = 1'b0;

    // reset values
    #12;
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_payload", {m_tdata, m_tkeep, m_tlast, m_tuser}, '0);
    check("rst_fill", fill_level, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_trunc_cnt", trunc_cnt, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_reset", s_tready, 1'b1);

    // 1: backpressure fill, then release
    fork
      begin
        send(64'h1, 1'b0, 2'b00, K_PASS, 1'b0);
        send(64'h2, 1'b0, 2'b00, K_PASS, 1'b0);
        send(64'h3, 1'b1, 2'b00, K_PASS, 1'b0);
        send(64'h4, 1'b0, 2'b00, K_PASS, 1'b0);
        send(64'h5, 1'b0, 2'b00, K_PASS, 1'b0);
        send(64'h6, 1'b1, 2'b00, K_PASS, 1'b0);
      end
      begin
        repeat (7) @(posedge clk);
        #1;
        check("full_s_tready", s_tready, 1'b0);
        check("full_fill", fill_level, 4);
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_reassert", s_tready, 1'b1);
        check("fill_after_read", fill_level, 3);
      end
    join
    wait_drain();
    check("t1_frame_cnt", frame_cnt, 2);
    check("t1_trunc_cnt", trunc_cnt, 0);

    // 2/4: back-to-back latency, limit-length frame with genuine tlast
    lat_chk = 1'b1;
    send(64'h10, 1'b0, 2'b00, K_PASS, 1'b1);
    send(64'h11, 1'b0, 2'b00, K_PASS, 1'b1);
    send(64'h12, 1'b0, 2'b00, K_PASS, 1'b1);
    send(64'h13, 1'b1, 2'b00, K_PASS, 1'b1);
    send(64'h20, 1'b0, 2'b10, K_PASS, 1'b1);
    send(64'h21, 1'b0, 2'b01, K_PASS, 1'b1);
    send(64'h22, 1'b1, 2'b10, K_PASS, 1'b1);
    wait_drain();
    lat_chk = 1'b0;
    check("t2_frame_cnt", frame_cnt, 4);
    check("t2_trunc_cnt", trunc_cnt, 0);

    // 3: truncation with the FIFO held full; discarded beats never stall
    m_tready = 1'b0;
    send(64'hA0, 1'b0, 2'b00, K_PASS,  1'b0);
    send(64'hA1, 1'b0, 2'b00, K_PASS,  1'b0);
    send(64'hA2, 1'b0, 2'b10, K_PASS,  1'b0);
    send(64'hA3, 1'b0, 2'b10, K_TRUNC, 1'b0);
    send(64'hA4, 1'b0, 2'b00, K_DROP,  1'b1);
    send(64'hA5, 1'b0, 2'b00, K_DROP,  1'b1);
    send(64'hA6, 1'b1, 2'b00, K_DROP,  1'b1);
    check("t3_fill", fill_level, 4);
    check("t3_trunc_cnt", trunc_cnt, 1);
    check("t3_frame_cnt", frame_cnt, 5);
    check("t3_ready_full_idle", s_tready, 1'b0);
    m_tready = 1'b1;
    send(64'hB0, 1'b0, 2'b00, K_PASS, 1'b0);
    send(64'hB1, 1'b1, 2'b00, K_PASS, 1'b0);
    wait_drain();
    check("t3_frame_after", frame_cnt, 6);
    check("t3_trunc_after", trunc_cnt, 1);

    // 5: FIFO kept near full while m_tready toggles each cycle
    m_tready = 1'b0;
    saw_full = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 4; f++) begin
          for (int b = 0; b < 3; b++) begin
            send(64'(32'h300 + f * 16 + b), (b == 2), UW'(f), K_PASS, 1'b0);
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    wait_drain();
    check("t5_reached_full", saw_full, 1'b1);
    check("t5_frame_cnt", frame_cnt, 10);

    // 6: reset in the middle of a frame
    m_tready = 1'b0;
    send(64'hC0, 1'b0, 2'b00, K_PASS, 1'b0);
    send(64'hC1, 1'b0, 2'b00, K_PASS, 1'b0);
    send(64'hC2, 1'b0, 2'b00, K_PASS, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", m_tvalid, 1'b0);
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_trunc_cnt", trunc_cnt, 0);
    check("mid_rst_s_tready", s_tready, 1'b0);
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_ready", s_tready, 1'b1);
    m_tready = 1'b1;
    send(64'hD0, 1'b0, 2'b01, K_PASS, 1'b0);
    send(64'hD1, 1'b0, 2'b00, K_PASS, 1'b0);
    send(64'hD2, 1'b0, 2'b00, K_PASS, 1'b0);
    send(64'hD3, 1'b1, 2'b00, K_PASS, 1'b0);
    wait_drain();
    check("post_rst_frame_cnt", frame_cnt, 1);
    check("post_rst_trunc_cnt", trunc_cnt, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_ingress_fifo.md
Name: axis_ingress_fifo

Overview:
Parametrised buffered ingress stage for the parser's AXI-Stream input. It replaces the pure pass-through with a first-word-fall-through FIFO that decouples external backpressure from the internal pipeline. It enforces a maximum frame length: oversize frames are truncated, flagged and drained. It keeps saturating frame and truncation statistics. It sits between the external MAC/stream source and the header parser.

Parameters:
DATA_WIDTH, 64, tdata width in bits; multiple of 8, >=8
USER_WIDTH, 1, tuser width; bit 0 is the error flag
DEPTH, 16, FIFO entries; power of two, >=2
MAX_BEATS, 190, maximum beats per frame, >=1; truncation threshold
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_tdata  in  DATA_WIDTH  external data
s_tkeep  in  DATA_WIDTH/8  external byte enables
s_tvalid  in  1  external valid
s_tready  out  1  ready to external source
s_tlast  in  1  external end of frame
s_tuser  in  USER_WIDTH  external sideband; bit0 = upstream error
m_tdata  out  DATA_WIDTH  internal data
m_tkeep  out  DATA_WIDTH/8  internal byte enables
m_tvalid  out  1  internal valid
m_tready  in  1  internal ready
m_tlast  out  1  internal end of frame
m_tuser  out  USER_WIDTH  internal sideband
frame_cnt  out  CNT_WIDTH  frames written to FIFO (tlast beats), saturating
trunc_cnt  out  CNT_WIDTH  frames truncated, saturating
fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: s_tready=0 while rst_n=0; after reset s_tready=1 (FIFO empty, state IDLE). m_tvalid=0, m_tdata/m_tkeep/m_tlast/m_tuser=0, frame_cnt=0, trunc_cnt=0, fill_level=0, beat counter=0.
- Handshake: a beat is accepted on a rising edge with s_tvalid&&s_tready, and sent on m_tvalid&&m_tready.
- s_tready is a registered/state-derived signal with no combinational path from m_tready. In IDLE/IN_FRAME, s_tready = !full. In DISCARD, s_tready=1.
- Latency: a beat accepted at edge N is visible on m_* after edge N, i.e. m_tvalid is high in the following cycle. Zero-bubble: sustained throughput is 1 beat/cycle when m_tready=1.
- m_* outputs hold stable while m_tvalid=1 and m_tready=0.
- FIFO ordering is strict; no beat is reordered, duplicated or lost except in DISCARD.
- Read and write in the same cycle are permitted at any occupancy other than full. When full, s_tready=0, so no write occurs; a read that cycle frees a slot and s_tready rises next cycle.
- FSM states: IDLE (between frames), IN_FRAME, DISCARD. A beat counter bcnt counts accepted beats of the current frame.
- IDLE/IN_FRAME, accepted beat with s_tlast=1: write the beat unchanged, set bcnt=0, go to IDLE, frame_cnt+1.
- IDLE/IN_FRAME, accepted beat with s_tlast=0 and bcnt+1==MAX_BEATS: write the beat with tlast forced to 1 and tuser[0] forced to 1. Go to DISCARD; frame_cnt+1, trunc_cnt+1.
- IDLE/IN_FRAME, otherwise: write the beat, bcnt+1, go to IN_FRAME.
- Simultaneous s_tlast and limit reached: s_tlast wins, no truncation, no error flag.
- DISCARD: accepted beats are dropped, not written. On s_tlast go to IDLE and set bcnt=0. No counter change.
- MAX_BEATS=1: every multi-beat frame is truncated to its first beat.
- Counters saturate at all-ones and never wrap.
- Upstream tuser bits pass through. Bit 0 is ORed with the truncation flag.
- Reset mid-operation: FIFO contents are flushed, state returns to IDLE, counters clear. Any partial frame is lost with no tlast emitted. After reset the source must restart at a frame boundary.

Test Plan:
1. Backpressure fill: DEPTH=4, m_tready=0, push beats 0x1..0x6 -> s_tready=0 after 4 accepts, fill_level=4. Release m_tready -> output 0x1..0x6 in order, s_tready reasserts one cycle after the first read.
2. Latency/throughput: m_tready=1, 8-beat frame back-to-back -> each beat appears on m_* one cycle after acceptance, no bubbles, m_tlast on beat 8, frame_cnt=1.
3. Truncation: MAX_BEATS=4, 7-beat frame (data 0xA0..0xA6) -> 4 beats out (0xA0..0xA3), beat 0xA3 has tlast=1 and tuser[0]=1. Beats 0xA4..0xA6 are dropped with s_tready=1 throughout. trunc_cnt=1, frame_cnt=1. A following 2-beat frame passes unmodified.
4. Boundary: MAX_BEATS=4, 4-beat frame with s_tlast on beat 4 -> no error flag, trunc_cnt unchanged.
5. Full with concurrent read: keep FIFO at DEPTH with m_tready toggling every cycle -> no data loss, no write while s_tready=0, order preserved.
6. Reset mid-frame: assert rst_n=0 after 3 beats of a 6-beat frame -> m_tvalid=0 asynchronously, fill_level=0, counters=0. A fresh frame after release passes intact.
